write_resp_router: RTL and testbench

Return path for the AXI write channel of the 2-master interconnect. It records, in issue order, which master won each write-address handshake. It then routes each B-channel response from the shared slave port back to that master. It also backpressures the write-address arbitration path when the outstanding-transaction tracker is full.

---
 rtl/axi_ic_pkg.sv | 18 +
 rtl/write_resp_router_if.sv | 44 ++++
 rtl/write_resp_router_fifo.sv | 65 ++++++
 rtl/write_resp_router.sv | 114 +++++++++++
 tb/tb_write_resp_router.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the 2-master AXI interconnect.
package axi_ic_pkg;

    localparam int unsigned MASTERS_NUM               = 2;
    localparam int unsigned MASTER_ID_W               = $clog2(MASTERS_NUM);
    localparam int unsigned DEFAULT_OUTSTANDING_DEPTH = 4;
    localparam int unsigned ERR_CNT_W                 = 16;

    typedef logic [MASTER_ID_W-1:0] master_idx_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

endpackage

// File: rtl/write_resp_router_if.sv
// AW-issue tracking and B-channel bundle between the interconnect and write_resp_router.
interface write_resp_router_if
    import axi_ic_pkg::*;
#(
    parameter int unsigned Outstanding_Depth = DEFAULT_OUTSTANDING_DEPTH
);
    localparam int unsigned CNT_W = $clog2(Outstanding_Depth) + 1;

    logic                 AW_Fire;
    master_idx_t          AW_Master;
    logic                 Outstanding_Full;
    logic [CNT_W-1:0]     Outstanding_Count;
    logic                 M_AXI_bvalid;
    resp_t                M_AXI_bresp;
    logic                 M_AXI_bready;
    logic                 S00_AXI_bvalid;
    resp_t                S00_AXI_bresp;
    logic                 S00_AXI_bready;
    logic                 S01_AXI_bvalid;
    resp_t                S01_AXI_bresp;
    logic                 S01_AXI_bready;
    logic                 Unexpected_Resp;
    logic                 Overflow_Err;
    logic [ERR_CNT_W-1:0] Err_Resp_Count;

    // Router side
    modport slave (
        input  AW_Fire, AW_Master, M_AXI_bvalid, M_AXI_bresp,
               S00_AXI_bready, S01_AXI_bready,
        output Outstanding_Full, Outstanding_Count, M_AXI_bready,
               S00_AXI_bvalid, S00_AXI_bresp, S01_AXI_bvalid, S01_AXI_bresp,
               Unexpected_Resp, Overflow_Err, Err_Resp_Count
    );

    // Interconnect / environment side
    modport master (
        output AW_Fire, AW_Master, M_AXI_bvalid, M_AXI_bresp,
               S00_AXI_bready, S01_AXI_bready,
        input  Outstanding_Full, Outstanding_Count, M_AXI_bready,
               S00_AXI_bvalid, S00_AXI_bresp, S01_AXI_bvalid, S01_AXI_bresp,
               Unexpected_Resp, Overflow_Err, Err_Resp_Count
    );

endinterface

// File: rtl/write_resp_router_fifo.sv
// resp_order_fifo: generic synchronous FIFO with registered count/full/empty.
// A push while full is rejected; a pop while empty is ignored.
module resp_order_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       head_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int unsigned PTR_W = $clog2(Depth);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    // Accept/advance decisions; pointers wrap naturally since Depth is a power of 2
    always_comb begin
        push_ok  = push_i && !full_q;
        pop_ok   = pop_i && !empty_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(Depth));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage; entries need no reset because empty gates every read
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/write_resp_router.sv
// Write-response return path: records the AW winner order and routes each
// B response back to the master at the head of that order.
// Optional: define WRESP_ERR_CNT_EN to enable the SLVERR/DECERR counter.
module write_resp_router
    import axi_ic_pkg::*;
#(
    parameter int unsigned Outstanding_Depth = DEFAULT_OUTSTANDING_DEPTH
) (
    input  logic                ACLK,
    input  logic                ARESET,
    write_resp_router_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(Outstanding_Depth) + 1;

    master_idx_t      head;
    logic [CNT_W-1:0] count;
    logic             full, empty;
    logic             s00_bvalid_c, s01_bvalid_c, m_bready_c;
    resp_t            s00_bresp_c, s01_bresp_c;
    logic             b_hs_c;
    logic             unexp_q, unexp_d;
    logic             ovf_q, ovf_d;

    resp_order_fifo #(
        .Width (MASTER_ID_W),
        .Depth (Outstanding_Depth)
    ) u_order (
        .clk_i       (ACLK),
        .rst_i       (ARESET),
        .push_i      (bus.AW_Fire),
        .push_data_i (bus.AW_Master),
        .pop_i       (b_hs_c),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    // B routing; an empty tracker sinks and discards any slave response
    always_comb begin
        s00_bvalid_c = 1'b0;
        s01_bvalid_c = 1'b0;
        s00_bresp_c  = OKAY;
        s01_bresp_c  = OKAY;
        m_bready_c   = 1'b0;
        if (empty) begin
            m_bready_c = bus.M_AXI_bvalid;
        end else begin
            s00_bresp_c = bus.M_AXI_bresp;
            s01_bresp_c = bus.M_AXI_bresp;
            if (head == master_idx_t'(0)) begin
                s00_bvalid_c = bus.M_AXI_bvalid;
                m_bready_c   = bus.S00_AXI_bready;
            end else begin
                s01_bvalid_c = bus.M_AXI_bvalid;
                m_bready_c   = bus.S01_AXI_bready;
            end
        end
        b_hs_c = bus.M_AXI_bvalid && m_bready_c;
    end

    // Sticky error flag next-state
    always_comb begin
        unexp_d = unexp_q | (bus.M_AXI_bvalid && empty);
        ovf_d   = ovf_q | (bus.AW_Fire && full);
    end

    // Sticky error flag registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            unexp_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unexp_q <= unexp_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef WRESP_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating count of error responses, popped or discarded
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (b_hs_c && bus.M_AXI_bresp[1] && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // Error counter register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.Err_Resp_Count = err_cnt_q;
`else
    assign bus.Err_Resp_Count = '0;
`endif

    assign bus.S00_AXI_bvalid    = s00_bvalid_c;
    assign bus.S01_AXI_bvalid    = s01_bvalid_c;
    assign bus.S00_AXI_bresp     = s00_bresp_c;
    assign bus.S01_AXI_bresp     = s01_bresp_c;
    assign bus.M_AXI_bready      = m_bready_c;
    assign bus.Outstanding_Count = count;
    assign bus.Outstanding_Full  = full;
    assign bus.Unexpected_Resp   = unexp_q;
    assign bus.Overflow_Err      = ovf_q;

endmodule

// File: tb/tb_write_resp_router.sv
// Directed bench for write_resp_router (depth 4).
module tb_write_resp_router;
    import axi_ic_pkg::*;

    logic ACLK;
    logic ARESET;
    int   total;
    int   bad;
    int   exp_err;

    write_resp_router_if #(.Outstanding_Depth(4)) bus ();

    write_resp_router #(.Outstanding_Depth(4)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw(input logic m);
        bus.AW_Fire   = 1'b1;
        bus.AW_Master = master_idx_t'(m);
        tick();
        bus.AW_Fire   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
`ifdef WRESP_ERR_CNT_EN
        exp_err = 2;
`else
        exp_err = 0;
`endif
        ARESET             = 1'b1;
        bus.AW_Fire        = 1'b0;
        bus.AW_Master      = '0;
        bus.M_AXI_bvalid   = 1'b0;
        bus.M_AXI_bresp    = OKAY;
        bus.S00_AXI_bready = 1'b0;
        bus.S01_AXI_bready = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        #1;

        // Reset state
        chk("rst_count", 32'(bus.Outstanding_Count), 0);
        chk("rst_full", 32'(bus.Outstanding_Full), 0);
        chk("rst_unexp", 32'(bus.Unexpected_Resp), 0);
        chk("rst_ovf", 32'(bus.Overflow_Err), 0);
        chk("rst_err", 32'(bus.Err_Resp_Count), 0);
        chk("rst_mready", 32'(bus.M_AXI_bready), 0);
        chk("rst_s00v", 32'(bus.S00_AXI_bvalid), 0);
        chk("rst_s01v", 32'(bus.S01_AXI_bvalid), 0);

        // Issue order 0,1,1 then three OKAY responses
        @(posedge ACLK); #1;
        aw(1'b0); aw(1'b1); aw(1'b1);
        chk("iss_count3", 32'(bus.Outstanding_Count), 3);
        bus.M_AXI_bvalid = 1'b1; bus.M_AXI_bresp = OKAY;
        bus.S00_AXI_bready = 1'b1; bus.S01_AXI_bready = 1'b1;
        #1;
        chk("iss_r0_s00v", 32'(bus.S00_AXI_bvalid), 1);
        chk("iss_r0_s01v", 32'(bus.S01_AXI_bvalid), 0);
        chk("iss_r0_mrdy", 32'(bus.M_AXI_bready), 1);
        tick();
        chk("iss_count2", 32'(bus.Outstanding_Count), 2);
        chk("iss_r1_s00v", 32'(bus.S00_AXI_bvalid), 0);
        chk("iss_r1_s01v", 32'(bus.S01_AXI_bvalid), 1);
        tick();
        chk("iss_count1", 32'(bus.Outstanding_Count), 1);
        chk("iss_r2_s01v", 32'(bus.S01_AXI_bvalid), 1);
        tick();
        bus.M_AXI_bvalid = 1'b0;
        chk("iss_count0", 32'(bus.Outstanding_Count), 0);
        tick();
        chk("iss_unexp", 32'(bus.Unexpected_Resp), 0);

        // Backpressure on M1 at head
        aw(1'b1); aw(1'b0);
        bus.S01_AXI_bready = 1'b0; bus.S00_AXI_bready = 1'b1;
        bus.M_AXI_bvalid = 1'b1; bus.M_AXI_bresp = OKAY;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_s01v", 32'(bus.S01_AXI_bvalid), 1);
            chk("bp_s00v", 32'(bus.S00_AXI_bvalid), 0);
            chk("bp_mrdy", 32'(bus.M_AXI_bready), 0);
            chk("bp_count", 32'(bus.Outstanding_Count), 2);
            tick();
        end
        bus.S01_AXI_bready = 1'b1;
        #1;
        chk("bp_mrdy_up", 32'(bus.M_AXI_bready), 1);
        tick();
        chk("bp_pop_count", 32'(bus.Outstanding_Count), 1);
        chk("bp_next_s00v", 32'(bus.S00_AXI_bvalid), 1);
        tick();
        bus.M_AXI_bvalid = 1'b0;
        chk("bp_drain", 32'(bus.Outstanding_Count), 0);

        // Fill, overflow, then simultaneous push/pop at count 3
        aw(1'b0); aw(1'b1); aw(1'b0); aw(1'b1);
        chk("fill_count", 32'(bus.Outstanding_Count), 4);
        chk("fill_full", 32'(bus.Outstanding_Full), 1);
        aw(1'b1);
        chk("ovf_flag", 32'(bus.Overflow_Err), 1);
        chk("ovf_count", 32'(bus.Outstanding_Count), 4);
        bus.M_AXI_bvalid = 1'b1;
        tick();
        chk("pop_count3", 32'(bus.Outstanding_Count), 3);
        chk("pop_notfull", 32'(bus.Outstanding_Full), 0);
        aw(1'b0);
        chk("pp_count3", 32'(bus.Outstanding_Count), 3);
        chk("pp_notfull", 32'(bus.Outstanding_Full), 0);
        repeat (3) tick();
        bus.M_AXI_bvalid = 1'b0;
        chk("pp_drain", 32'(bus.Outstanding_Count), 0);
        chk("ovf_sticky", 32'(bus.Overflow_Err), 1);
        tick();

        // Error response counting
        aw(1'b0); aw(1'b1); aw(1'b0);
        bus.M_AXI_bvalid = 1'b1;
        bus.M_AXI_bresp = SLVERR; tick();
        bus.M_AXI_bresp = OKAY;   tick();
        bus.M_AXI_bresp = DECERR; tick();
        bus.M_AXI_bvalid = 1'b0; bus.M_AXI_bresp = OKAY;
        chk("err_count", 32'(bus.Err_Resp_Count), 32'(exp_err));
        chk("err_drain", 32'(bus.Outstanding_Count), 0);
        chk("err_unexp", 32'(bus.Unexpected_Resp), 0);

        // Response with empty tracker
        bus.M_AXI_bvalid = 1'b1;
        #1;
        chk("emp_mrdy", 32'(bus.M_AXI_bready), 1);
        chk("emp_s00v", 32'(bus.S00_AXI_bvalid), 0);
        chk("emp_s01v", 32'(bus.S01_AXI_bvalid), 0);
        tick();
        bus.M_AXI_bvalid = 1'b0;
        chk("emp_unexp", 32'(bus.Unexpected_Resp), 1);
        tick();
        chk("emp_unexp_held", 32'(bus.Unexpected_Resp), 1);
        chk("emp_err_same", 32'(bus.Err_Resp_Count), 32'(exp_err));

        // Asynchronous reset with two in flight
        aw(1'b0); aw(1'b1);
        chk("ar_count2", 32'(bus.Outstanding_Count), 2);
        #3 ARESET = 1'b1;
        #1;
        chk("ar_count", 32'(bus.Outstanding_Count), 0);
        chk("ar_full", 32'(bus.Outstanding_Full), 0);
        chk("ar_unexp", 32'(bus.Unexpected_Resp), 0);
        chk("ar_ovf", 32'(bus.Overflow_Err), 0);
        chk("ar_err", 32'(bus.Err_Resp_Count), 0);
        tick();
        ARESET = 1'b0;
        bus.M_AXI_bvalid = 1'b1; bus.M_AXI_bresp = OKAY;
        #1;
        chk("ar_resp_mrdy", 32'(bus.M_AXI_bready), 1);
        chk("ar_resp_s00v", 32'(bus.S00_AXI_bvalid), 0);
        tick();
        bus.M_AXI_bvalid = 1'b0;
        chk("ar_resp_unexp", 32'(bus.Unexpected_Resp), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
